// File: rtl/layer_2_accum_controller_if.sv
// Handshake bundle between the layer-2 accumulator sequencer and its neighbours:
// upstream MAC stage (in_*), the bias-add accumulator (acc_*) and the readout
// consumer (out_*). The controller side is the master.
interface layer_2_accum_controller_if;
    logic in_valid;
    logic in_ready;
    logic acc_reset;
    logic acc_load;
    logic acc_done;
    logic out_valid;
    logic out_ready;

    modport master (
        input  in_valid,
        input  acc_done,
        input  out_ready,
        output in_ready,
        output acc_reset,
        output acc_load,
        output out_valid
    );

    modport slave (
        output in_valid,
        output acc_done,
        output out_ready,
        input  in_ready,
        input  acc_reset,
        input  acc_load,
        input  out_valid
    );
endinterface

// File: rtl/layer_2_accum_controller.sv
// Layer-2 bias-add accumulator sequencer.
// One inference: pulse acc_reset (bias preload), admit NUM_PARTIALS partial-sum
// vectors with one acc_load each, wait for the matching acc_done echoes (bounded
// by TIMEOUT), then hold out_valid until the consumer takes the result.
module layer_2_accum_controller #(
    parameter int NUM_PARTIALS = 16,
    parameter int COUNT_W      = 8,
    parameter int TIMEOUT      = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic                        abort_i,
    layer_2_accum_controller_if.master  bus,
    output logic                        busy_o,
    output logic                        error_o,
    output logic [COUNT_W-1:0]          load_count_o
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [COUNT_W-1:0] NP_C     = COUNT_W'(NUM_PARTIALS);
    localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(NUM_PARTIALS - 1);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRELOAD   = 3'd1,
        ACCUM     = 3'd2,
        WAIT_DONE = 3'd3,
        RESULT    = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] load_count_q, load_count_d;
    logic [COUNT_W-1:0] ack_count_q, ack_count_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               error_q, error_d;
    logic               acc_reset_q, acc_reset_d;
    logic               out_valid_q, out_valid_d;

    logic               in_ready;
    logic               acc_load;
    logic               ack_inc;

    // An acknowledgement counts only while loads can be outstanding; the
    // counter saturates so a stray extra echo cannot wrap it.
    assign ack_inc = bus.acc_done && !abort_i && (ack_count_q != NP_C) &&
                     ((state_q == ACCUM) || (state_q == WAIT_DONE));

    // Next-state, counter updates and combinational handshake outputs.
    always_comb begin
        state_d      = state_q;
        load_count_d = load_count_q;
        ack_count_d  = ack_count_q;
        timer_d      = timer_q;
        error_d      = error_q;
        in_ready     = 1'b0;
        acc_load     = 1'b0;

        if (ack_inc) begin
            ack_count_d = ack_count_q + 1'b1;
        end

        if (abort_i) begin
            // Abort wins over everything, including start in IDLE. in_ready is
            // dropped too so upstream never sees a handshake that loads nothing.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d      = PRELOAD;
                        load_count_d = '0;
                        ack_count_d  = '0;
                        timer_d      = '0;
                        error_d      = 1'b0;
                    end
                end
                PRELOAD: begin
                    state_d = ACCUM;
                end
                ACCUM: begin
                    in_ready = 1'b1;
                    if (bus.in_valid) begin
                        acc_load     = 1'b1;
                        load_count_d = load_count_q + 1'b1;
                        if (load_count_q == LAST_IDX) begin
                            state_d = WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    timer_d = timer_q + 1'b1;
                    // Use the updated ack count so the final echo moves us to
                    // RESULT on the same edge it is counted.
                    if (ack_count_d == NP_C) begin
                        state_d = RESULT;
                    end else if (timer_q == TMR_LAST) begin
                        error_d = 1'b1;
                        state_d = RESULT;
                    end
                end
                RESULT: begin
                    if (out_valid_q && bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Registered outputs are decoded from the next state so they line up
    // exactly with the state they belong to.
    always_comb begin
        acc_reset_d = (state_d == PRELOAD);
        out_valid_d = (state_d == RESULT);
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            load_count_q <= '0;
            ack_count_q  <= '0;
            timer_q      <= '0;
            error_q      <= 1'b0;
            acc_reset_q  <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_count_q <= load_count_d;
            ack_count_q  <= ack_count_d;
            timer_q      <= timer_d;
            error_q      <= error_d;
            acc_reset_q  <= acc_reset_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.acc_load  = acc_load;
    assign bus.acc_reset = acc_reset_q;
    assign bus.out_valid = out_valid_q;
    assign busy_o        = (state_q != IDLE);
    assign error_o       = error_q;
    assign load_count_o  = load_count_q;

    // The vector count can never run past one inference's worth.
    a_load_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        load_count_q <= NP_C);

    // Every load corresponds to a completed upstream handshake.
    a_load_hs: assert property (@(posedge clk_i) disable iff (!rst_ni)
        acc_load |-> (in_ready && bus.in_valid));

endmodule

// File: doc/layer_2_accum_controller.md
Name: layer_2_accum_controller

Overview:
Sequencer for the layer-2 bias-add accumulator. Per inference it preloads the biases by pulsing the accumulator's synchronous reset, then admits exactly NUM_PARTIALS partial-sum vectors from the upstream MAC stage through a valid/ready handshake, issuing one accumulator load per accepted vector. It confirms completion by counting the accumulator's done acknowledgements, then holds a result-valid handshake toward the layer-2 consumer (argmax/readout).

Parameters:
NUM_PARTIALS, 16, partial-sum vectors accumulated per inference (>=1)
COUNT_W, 8, counter width; 2**COUNT_W > NUM_PARTIALS
TIMEOUT, 64, cycles allowed in WAIT_DONE for remaining acknowledgements before flagging an error

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin an inference; sampled only in IDLE
abort  input  1  synchronous abort; returns to IDLE from any state
in_valid  input  1  upstream partial-sum vector valid
in_ready  output  1  controller accepts a vector this cycle
acc_reset  output  1  to accumulator reset (active-high, synchronous): bias preload
acc_load  output  1  to accumulator load
acc_done  input  1  accumulator done (registered copy of load)
out_valid  output  1  accumulated outputs are final
out_ready  input  1  consumer takes the result
busy  output  1  state != IDLE
error  output  1  sticky: acknowledgement timeout in the current inference
load_count  output  COUNT_W  vectors accepted in the current inference

Behaviour:
- reset low (async): state IDLE; load_count=0; ack_count=0; timer=0; error=0; acc_reset=0; out_valid=0. Combinational outputs in_ready, acc_load, busy are 0 in IDLE.
- States: IDLE, PRELOAD, ACCUM, WAIT_DONE, RESULT.
- IDLE: start=1 -> PRELOAD; same edge clears load_count, ack_count, timer and error.
- PRELOAD: registered acc_reset=1 for exactly one cycle; in_ready=0 -> ACCUM.
- ACCUM: in_ready=1. acc_load = in_valid & in_ready (combinational, same cycle as the accepted vector); load_count++ per accept. Back-to-back accepts are allowed. Accept with load_count==NUM_PARTIALS-1 -> WAIT_DONE; in_ready=0 from the next cycle.
- ack_count increments on every cycle acc_done=1 while in ACCUM or WAIT_DONE. Saturates at NUM_PARTIALS.
- WAIT_DONE: in_ready=0, acc_load=0, timer++ each cycle. ack_count==NUM_PARTIALS -> RESULT. timer==TIMEOUT-1 without that -> error=1, RESULT. Normal latency: RESULT entered 2 cycles after the final accept.
- RESULT: out_valid=1 (registered), held until out_ready=1. out_valid&out_ready -> IDLE; out_valid=0 the next cycle. acc_reset is not asserted on exit: outputs stay stable until the next start.
- start outside IDLE is ignored. start and abort together in IDLE: abort wins and the state stays IDLE.
- abort=1 in any state -> IDLE next edge. acc_reset and out_valid deassert. acc_load is forced 0 that cycle. Counters are left as is. error is left as is.
- in_valid in IDLE/PRELOAD/WAIT_DONE/RESULT is not accepted; upstream holds its data (no drop, no load).
- Counters are unsigned COUNT_W bits. load_count never exceeds NUM_PARTIALS.
- Reset deasserting mid-inference restarts cleanly in IDLE. The accumulator contents are stale until the next PRELOAD.

Test Plan:
- NUM_PARTIALS=4, start, in_valid held high -> acc_reset high for 1 cycle, then 4 consecutive acc_load pulses, load_count 1..4. acc_done is echoed by a model with 1-cycle delay. out_valid rises 2 cycles after the 4th accept.
- Same configuration, in_valid toggles 1,0,1,0,... -> exactly 4 acc_load pulses, only on in_valid=1 cycles; out_valid follows the last ack by 1 cycle; error=0.
- out_ready held low for 10 cycles in RESULT -> out_valid stays 1 and busy=1. out_ready=1 -> IDLE next cycle, out_valid=0.
- Model suppresses the final acc_done, TIMEOUT=8 -> WAIT_DONE lasts 8 cycles, then error=1 and out_valid=1. The next start clears error to 0.
- abort during ACCUM after 2 accepts -> IDLE next cycle; in_ready=0, acc_load=0; load_count reads 2. A new start restarts with PRELOAD and load_count=0.
- Assert reset low during WAIT_DONE (asynchronous, mid-cycle) -> out_valid, busy and error are 0 immediately. start is ignored until reset is high, then the sequence completes normally.
